// File: rtl/motor_pkg.sv
// Shared constants and helpers for the motor PWM driver.
//   PWM_MAX / PWM_LAST_CNT : duty full scale and last counter value of a period
//   DUTY_W                 : width of duty and PWM counter values
//   DIR_FWD / DIR_REV      : direction encodings (FWD drives motor_in1)
//   ST_*                   : FSM state encodings
//   ramp_duty()            : one slew-limited step of applied duty toward a target
package motor_pkg;

    localparam int unsigned PWM_MAX      = 255;
    localparam int unsigned PWM_LAST_CNT = 254;
    localparam int unsigned DUTY_W       = $clog2(PWM_MAX + 1);

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;
    localparam logic [1:0] ST_DEAD = 2'd3;

    // Move applied toward target by at most step; the upward sum is kept at
    // DUTY_W+1 bits so it saturates at target instead of wrapping.
    function automatic logic [DUTY_W-1:0] ramp_duty(
        input logic [DUTY_W-1:0] applied,
        input logic [DUTY_W-1:0] target,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W:0] up;
        up        = {1'b0, applied} + {1'b0, step};
        ramp_duty = applied;
        if (target > applied) begin
            ramp_duty = (up > {1'b0, target}) ? target : up[DUTY_W-1:0];
        end else if (target < applied) begin
            ramp_duty = ((applied - target) > step) ? (applied - step) : target;
        end
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clock prescaler plus 0..PWM_LAST_CNT period counter.
//   clk, rst    : clock, asynchronous active-high reset
//   cnt         : current PWM count (registered)
//   tick_c      : prescaler at its last cycle, cnt advances on this clock
//   boundary_c  : tick on the last count, i.e. the final clock of a period
module pwm_timebase
    import motor_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DUTY_W-1:0] cnt,
    output logic              tick_c,
    output logic              boundary_c
);

    localparam int unsigned       PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_LAST_CNT);

    logic [PRE_W-1:0] prescaler;

    assign tick_c     = (prescaler == PRE_LAST);
    assign boundary_c = tick_c && (cnt == CNT_LAST);

    // Prescaler and period counter; the counter wraps after the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            cnt       <= '0;
        end else begin
            prescaler <= tick_c ? '0 : prescaler + 1'b1;
            if (tick_c) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver with period-aligned duty updates, per-period slew
// limiting and sequenced (ramp-down, dead time, re-drive) direction reversal.
//   clk, rst      : clock, asynchronous active-high reset
//   enable, dir   : run request and requested direction
//   pwm_duty      : target duty, 0 = 0 %, 255 = 100 %
//   motor_in1/2   : H-bridge inputs (forward drives in1, reverse drives in2)
//   pwm_out       : raw registered PWM waveform
//   applied_duty  : duty currently in effect
//   period_start  : one-clock pulse on the first cycle of each period
//   busy          : high while stopping or in the dead interval
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned RAMP_STEP    = 8,
    parameter int unsigned DEAD_PERIODS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              dir,
    input  logic [DUTY_W-1:0] pwm_duty,
    output logic              motor_in1,
    output logic              motor_in2,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] applied_duty,
    output logic              period_start,
    output logic              busy
);

    localparam int unsigned       DEAD_W    = $clog2(DEAD_PERIODS + 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS);
    localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);

    logic [DUTY_W-1:0] cnt;
    logic              boundary;

    logic [1:0]        state, state_nxt;
    logic              dir_q, dir_q_nxt;
    logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;
    logic [DUTY_W-1:0] applied_nxt;
    logic [DUTY_W-1:0] target;
    logic              pwm_c, drive_c;

    pwm_timebase #(
        .CLK_DIV(CLK_DIV)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .tick_c    (),
        .boundary_c(boundary)
    );

    // FSM state and the registers it owns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            dir_q        <= DIR_FWD;
            dead_cnt     <= '0;
            applied_duty <= '0;
        end else begin
            state        <= state_nxt;
            dir_q        <= dir_q_nxt;
            dead_cnt     <= dead_cnt_nxt;
            applied_duty <= applied_nxt;
        end
    end

    // Next state, ramp and dead-time sequencing; all changes land on period
    // boundaries except leaving IDLE.
    always_comb begin
        state_nxt    = state;
        dir_q_nxt    = dir_q;
        dead_cnt_nxt = dead_cnt;
        applied_nxt  = applied_duty;
        target       = (state == ST_RUN) ? pwm_duty : '0;

        if (boundary) begin
            applied_nxt = ramp_duty(applied_duty, target, STEP);
        end

        case (state)
            ST_IDLE: begin
                applied_nxt = '0;
                if (enable) begin
                    state_nxt = ST_RUN;
                    dir_q_nxt = dir;
                end
            end
            ST_RUN: begin
                if (boundary && (!enable || (dir != dir_q))) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Request restored before reaching zero: resume without dead time.
                if (boundary) begin
                    if (enable && (dir == dir_q)) begin
                        state_nxt = ST_RUN;
                    end else if (applied_nxt == '0) begin
                        state_nxt    = ST_DEAD;
                        dead_cnt_nxt = '0;
                    end
                end
            end
            ST_DEAD: begin
                if (boundary) begin
                    dead_cnt_nxt = dead_cnt + 1'b1;
                    if (dead_cnt_nxt == DEAD_LAST) begin
                        if (enable) begin
                            state_nxt = ST_RUN;
                            dir_q_nxt = dir;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pwm_c   = (cnt < applied_duty);
    assign drive_c = pwm_c && ((state == ST_RUN) || (state == ST_STOP));

    // Registered outputs; direction select is exclusive so in1/in2 never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out      <= 1'b0;
            motor_in1    <= 1'b0;
            motor_in2    <= 1'b0;
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            pwm_out      <= pwm_c;
            motor_in1    <= drive_c && (dir_q == DIR_FWD);
            motor_in2    <= drive_c && (dir_q == DIR_REV);
            period_start <= boundary;
            busy         <= (state_nxt == ST_STOP) || (state_nxt == ST_DEAD);
        end
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed self-checking bench for motor_pwm_driver at default parameters
// (period 1020 clk, step 8, two dead periods).
module tb_motor_pwm_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       dir;
    logic [7:0] pwm_duty;
    logic       motor_in1, motor_in2, pwm_out, period_start, busy;
    logic [7:0] applied_duty;

    int checks = 0;
    int errors = 0;

    // Per-period measurements filled by run_period.
    int ncyc, hp, h1, h2, both, nbusy;

    motor_pwm_driver #(
        .CLK_DIV     (4),
        .RAMP_STEP   (8),
        .DEAD_PERIODS(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .dir         (dir),
        .pwm_duty    (pwm_duty),
        .motor_in1   (motor_in1),
        .motor_in2   (motor_in2),
        .pwm_out     (pwm_out),
        .applied_duty(applied_duty),
        .period_start(period_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Step negedge by negedge until the next period_start, counting high
    // cycles of each output on the way (bounded at 1100 cycles).
    task automatic run_period();
        ncyc = 0; hp = 0; h1 = 0; h2 = 0; both = 0; nbusy = 0;
        do begin
            if (pwm_out) hp++;
            if (motor_in1) h1++;
            if (motor_in2) h2++;
            if (motor_in1 && motor_in2) both++;
            if (!busy) nbusy++;
            @(negedge clk);
            ncyc++;
        end while (!period_start && ncyc < 1100);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; dir = 1'b0; pwm_duty = 8'd0;
        repeat (3) @(negedge clk);
        checks++; if ({motor_in1, motor_in2, pwm_out, period_start, busy} !== 5'b0) begin errors++; $display("FAIL reset_outputs got %b exp 00000", {motor_in1, motor_in2, pwm_out, period_start, busy}); end
        checks++; if (applied_duty !== 8'd0) begin errors++; $display("FAIL reset_applied got %0d exp 0", applied_duty); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if ({motor_in1, motor_in2, busy} !== 3'b0) begin errors++; $display("FAIL idle_outputs got %b exp 000", {motor_in1, motor_in2, busy}); end
        checks++; if (applied_duty !== 8'd0) begin errors++; $display("FAIL idle_applied got %0d exp 0", applied_duty); end
    endtask

    task automatic test_ramp_up();
        enable = 1'b1; dir = 1'b0; pwm_duty = 8'd64;
        for (int k = 1; k <= 8; k++) begin
            run_period();
            checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL ramp_up_timeout k=%0d got %0d cycles", k, ncyc); end
            checks++; if (applied_duty !== 8'(8 * k)) begin errors++; $display("FAIL ramp_up_applied k=%0d got %0d exp %0d", k, applied_duty, 8 * k); end
            checks++; if (h2 !== 0) begin errors++; $display("FAIL ramp_up_in2 k=%0d got %0d exp 0", k, h2); end
        end
        run_period();
        checks++; if (ncyc !== 1020) begin errors++; $display("FAIL steady_period got %0d exp 1020", ncyc); end
        checks++; if (h1 !== 256) begin errors++; $display("FAIL steady_in1_high got %0d exp 256", h1); end
        checks++; if (hp !== 256) begin errors++; $display("FAIL steady_pwm_high got %0d exp 256", hp); end
        checks++; if (h2 !== 0) begin errors++; $display("FAIL steady_in2_high got %0d exp 0", h2); end
    endtask

    // Enable drops for three boundaries, then returns with the same direction.
    task automatic test_enable_pause();
        repeat (100) @(negedge clk);
        enable = 1'b0;
        run_period();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pause_busy got %b exp 1", busy); end
        checks++; if (applied_duty !== 8'd64) begin errors++; $display("FAIL pause_b0_applied got %0d exp 64", applied_duty); end
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) enable = 1'b1;
            run_period();
            checks++; if (applied_duty !== 8'(64 - 8 * k)) begin errors++; $display("FAIL pause_applied k=%0d got %0d exp %0d", k, applied_duty, 64 - 8 * k); end
            checks++; if (nbusy !== 0) begin errors++; $display("FAIL pause_busy_low k=%0d got %0d exp 0", k, nbusy); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pause_resume_busy got %b exp 0", busy); end
        for (int k = 1; k <= 3; k++) begin
            run_period();
            checks++; if (applied_duty !== 8'(40 + 8 * k)) begin errors++; $display("FAIL resume_applied k=%0d got %0d exp %0d", k, applied_duty, 40 + 8 * k); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL resume_busy k=%0d got %b exp 0", k, busy); end
        end
    endtask

    task automatic test_reversal();
        repeat (100) @(negedge clk);
        dir = 1'b1;
        run_period();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rev_stop_busy got %b exp 1", busy); end
        checks++; if (applied_duty !== 8'd64) begin errors++; $display("FAIL rev_b0_applied got %0d exp 64", applied_duty); end
        for (int j = 1; j <= 8; j++) begin
            run_period();
            checks++; if (h1 !== 4 * (64 - 8 * (j - 1))) begin errors++; $display("FAIL rev_down_in1 j=%0d got %0d exp %0d", j, h1, 4 * (64 - 8 * (j - 1))); end
            checks++; if (h2 !== 0 || both !== 0) begin errors++; $display("FAIL rev_down_in2 j=%0d got in2=%0d both=%0d exp 0", j, h2, both); end
            checks++; if (nbusy !== 0) begin errors++; $display("FAIL rev_down_busy j=%0d got %0d idle cycles exp 0", j, nbusy); end
            checks++; if (applied_duty !== 8'(64 - 8 * j)) begin errors++; $display("FAIL rev_down_applied j=%0d got %0d exp %0d", j, applied_duty, 64 - 8 * j); end
        end
        for (int j = 1; j <= 2; j++) begin
            run_period();
            checks++; if (ncyc !== 1020) begin errors++; $display("FAIL dead_len j=%0d got %0d exp 1020", j, ncyc); end
            checks++; if (h1 !== 0 || h2 !== 0) begin errors++; $display("FAIL dead_drive j=%0d got in1=%0d in2=%0d exp 0", j, h1, h2); end
            checks++; if (nbusy !== 0) begin errors++; $display("FAIL dead_busy j=%0d got %0d idle cycles exp 0", j, nbusy); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rev_redrive_busy got %b exp 0", busy); end
        checks++; if (applied_duty !== 8'd0) begin errors++; $display("FAIL rev_redrive_applied got %0d exp 0", applied_duty); end
        for (int j = 1; j <= 8; j++) begin
            run_period();
            checks++; if (h2 !== 32 * (j - 1)) begin errors++; $display("FAIL rev_up_in2 j=%0d got %0d exp %0d", j, h2, 32 * (j - 1)); end
            checks++; if (h1 !== 0 || both !== 0) begin errors++; $display("FAIL rev_up_in1 j=%0d got in1=%0d both=%0d exp 0", j, h1, both); end
            checks++; if (applied_duty !== 8'(8 * j)) begin errors++; $display("FAIL rev_up_applied j=%0d got %0d exp %0d", j, applied_duty, 8 * j); end
        end
    endtask

    // Target changes mid-period: the running period keeps the old duty.
    task automatic test_mid_change();
        int hp0;
        hp0 = 0;
        for (int i = 0; i < 500; i++) begin
            if (pwm_out) hp0++;
            @(negedge clk);
        end
        pwm_duty = 8'd128;
        run_period();
        checks++; if (hp0 + hp !== 256) begin errors++; $display("FAIL mid_change_high got %0d exp 256", hp0 + hp); end
        checks++; if (ncyc + 500 !== 1020) begin errors++; $display("FAIL mid_change_spacing got %0d exp 1020", ncyc + 500); end
        checks++; if (applied_duty !== 8'd72) begin errors++; $display("FAIL mid_change_applied got %0d exp 72", applied_duty); end
        for (int j = 2; j <= 8; j++) begin
            run_period();
            checks++; if (ncyc !== 1020) begin errors++; $display("FAIL mid_spacing j=%0d got %0d exp 1020", j, ncyc); end
            checks++; if (hp !== 4 * (64 + 8 * (j - 1)) || h2 !== hp || h1 !== 0) begin errors++; $display("FAIL mid_high j=%0d got pwm=%0d in2=%0d in1=%0d exp %0d", j, hp, h2, h1, 4 * (64 + 8 * (j - 1))); end
            checks++; if (applied_duty !== 8'(64 + 8 * j)) begin errors++; $display("FAIL mid_applied j=%0d got %0d exp %0d", j, applied_duty, 64 + 8 * j); end
        end
    endtask

    // Ramp to full scale must saturate at 255, giving a constant-high output.
    task automatic test_full_duty();
        int exp_d;
        pwm_duty = 8'd255;
        for (int j = 1; j <= 16; j++) begin
            run_period();
            exp_d = (128 + 8 * j > 255) ? 255 : 128 + 8 * j;
            checks++; if (applied_duty !== 8'(exp_d)) begin errors++; $display("FAIL full_applied j=%0d got %0d exp %0d", j, applied_duty, exp_d); end
        end
        run_period();
        run_period();
        checks++; if (hp !== 1020 || h2 !== 1020) begin errors++; $display("FAIL full_high got pwm=%0d in2=%0d exp 1020", hp, h2); end
        checks++; if (applied_duty !== 8'd255) begin errors++; $display("FAIL full_hold got %0d exp 255", applied_duty); end
    endtask

    // Reset while the bridge is driving must coast it without waiting for a clock.
    task automatic test_reset_mid_run();
        repeat (10) @(negedge clk);
        checks++; if ({pwm_out, motor_in1, motor_in2} !== 3'b101) begin errors++; $display("FAIL pre_reset_drive got %b exp 101", {pwm_out, motor_in1, motor_in2}); end
        rst = 1'b1;
        #1;
        checks++; if ({pwm_out, motor_in1, motor_in2, busy, period_start} !== 5'b0) begin errors++; $display("FAIL async_reset_outputs got %b exp 00000", {pwm_out, motor_in1, motor_in2, busy, period_start}); end
        checks++; if (applied_duty !== 8'd0) begin errors++; $display("FAIL async_reset_applied got %0d exp 0", applied_duty); end
        repeat (3) @(negedge clk);
        rst = 1'b0; enable = 1'b0; dir = 1'b0; pwm_duty = 8'd0;
        repeat (20) @(negedge clk);
        checks++; if ({motor_in1, motor_in2, busy} !== 3'b0 || applied_duty !== 8'd0) begin errors++; $display("FAIL post_reset_idle got drive=%b applied=%0d exp 000 0", {motor_in1, motor_in2, busy}, applied_duty); end
    endtask

    // Zero duty from IDLE stays low; then the ramp restarts from zero.
    task automatic test_zero_duty();
        enable = 1'b1;
        run_period();
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL zero_timeout got %0d cycles", ncyc); end
        checks++; if (hp !== 0 || applied_duty !== 8'd0) begin errors++; $display("FAIL zero_first got pwm=%0d applied=%0d exp 0 0", hp, applied_duty); end
        run_period();
        checks++; if (hp !== 0 || h1 !== 0 || busy !== 1'b0) begin errors++; $display("FAIL zero_second got pwm=%0d in1=%0d busy=%b exp 0 0 0", hp, h1, busy); end
        pwm_duty = 8'd64;
        run_period();
        checks++; if (applied_duty !== 8'd8) begin errors++; $display("FAIL restart_applied got %0d exp 8", applied_duty); end
        run_period();
        checks++; if (h1 !== 32 || h2 !== 0) begin errors++; $display("FAIL restart_in1 got in1=%0d in2=%0d exp 32 0", h1, h2); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_enable_pause();
        test_reversal();
        test_mid_change();
        test_full_duty();
        test_reset_mid_run();
        test_zero_duty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
